umem_arbiter: RTL and testbench

//  Shares one single-port synchronous BSRAM between the core's instruction-fetch port (I, read-only)
//  and its load/store port (D, read/write with byte strobes). This lets the pipelined core run from
//  one unified memory instead of separate imem/dmem.

---
 rtl/umem_arbiter.sv | 122 ++++++++++++
 tb/tb_umem_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/umem_arbiter.sv
// umem_arbiter
//   Shares one single-port synchronous BSRAM between the core's instruction
//   fetch port (I, read-only) and its load/store port (D, read/write with byte
//   strobes). One access per cycle; D wins contention until it has taken
//   D_STREAK_MAX contended grants in a row, then I is forced through once.
//   Grants are combinational; read data returns one cycle after the grant.
//
//   Ports
//     clk, rst_n                      clock, synchronous active-low reset
//     i_req/i_addr -> i_gnt           fetch request / byte address / accept
//     i_rvalid/i_rdata                fetch response (1 cycle after i_gnt)
//     d_req/d_we/d_addr/d_wdata       load/store request (d_we=0 -> load)
//     d_gnt, d_rvalid/d_rdata         accept, load response
//     m_ce/m_we/m_addr/m_wdata        memory access strobe and write side
//     m_rdata                         memory read data (1 cycle after m_ce)
//
//   Response owner states
//     state    | meaning
//     OWN_NONE | no read in flight; m_rdata this cycle belongs to nobody
//     OWN_I    | fetch granted last cycle; m_rdata goes to the I port
//     OWN_D    | load granted last cycle; m_rdata goes to the D port

module umem_arbiter #(
  parameter int ADDR_W       = 11,
  parameter int D_STREAK_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [31:0]       i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic [3:0]        d_we,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              m_ce,
  output logic [3:0]        m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [31:0]       m_wdata,
  input  logic [31:0]       m_rdata
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  localparam logic [3:0] STREAK_LIM = 4'(D_STREAK_MAX);

  owner_t      owner_q, owner_d;
  logic [3:0]  streak_q, streak_d;
  logic [31:0] i_hold_q, d_hold_q;

  // Byte-offset bits and bits above the memory size are ignored (address wraps).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr[31:ADDR_W+2], i_addr[1:0],
                              d_addr[31:ADDR_W+2], d_addr[1:0]};

  always_comb begin
    i_gnt    = 1'b0;
    d_gnt    = 1'b0;
    m_ce     = 1'b0;
    m_we     = 4'b0000;
    m_addr   = i_addr[ADDR_W+1:2];
    m_wdata  = d_wdata;
    owner_d  = OWN_NONE;
    streak_d = streak_q;

    if (rst_n) begin
      if (d_req && !(i_req && streak_q == STREAK_LIM)) begin
        d_gnt = 1'b1;
      end else if (i_req) begin
        i_gnt = 1'b1;
      end
    end

    if (d_gnt) begin
      m_ce    = 1'b1;
      m_we    = d_we;
      m_addr  = d_addr[ADDR_W+1:2];
      owner_d = (d_we == 4'b0000) ? OWN_D : OWN_NONE;
    end else if (i_gnt) begin
      m_ce    = 1'b1;
      owner_d = OWN_I;
    end

    // Only contended D grants count toward the limit; the streak hits the
    // limit exactly when I is forced through, which clears it again.
    if (i_req && d_req && d_gnt) begin
      streak_d = streak_q + 4'd1;
    end else if (i_gnt || !i_req) begin
      streak_d = 4'd0;
    end
  end

  // Gating with rst_n drops a response whose grant landed just before reset.
  assign i_rvalid = rst_n && (owner_q == OWN_I);
  assign d_rvalid = rst_n && (owner_q == OWN_D);
  assign i_rdata  = i_rvalid ? m_rdata : i_hold_q;
  assign d_rdata  = d_rvalid ? m_rdata : d_hold_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner_q  <= OWN_NONE;
      streak_q <= 4'd0;
      i_hold_q <= 32'd0;
      d_hold_q <= 32'd0;
    end else begin
      owner_q  <= owner_d;
      streak_q <= streak_d;
      if (i_rvalid) i_hold_q <= m_rdata;
      if (d_rvalid) d_hold_q <= m_rdata;
    end
  end

endmodule

// File: tb/tb_umem_arbiter.sv
// tb_umem_arbiter
//   Directed bench for umem_arbiter with a behavioural single-port BSRAM.
//   Inputs change 1 ns after posedge; outputs are sampled on the negedge.

module tb_umem_arbiter;

  localparam int ADDR_W = 11;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              i_req = 1'b0;
  logic [31:0]       i_addr = '0;
  logic              i_gnt;
  logic              i_rvalid;
  logic [31:0]       i_rdata;
  logic              d_req = 1'b0;
  logic [3:0]        d_we = '0;
  logic [31:0]       d_addr = '0;
  logic [31:0]       d_wdata = '0;
  logic              d_gnt;
  logic              d_rvalid;
  logic [31:0]       d_rdata;
  logic              m_ce;
  logic [3:0]        m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [31:0]       m_wdata;
  logic [31:0]       m_rdata = '0;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_i_hold = '0;
  logic [31:0] exp_d_hold = '0;

  logic [31:0] mem [0:(1<<ADDR_W)-1];

  umem_arbiter #(.ADDR_W(ADDR_W), .D_STREAK_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_ce(m_ce), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int w);
    return 32'hC0DE_0000 | 32'(w & 16'hFFFF);
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0] we);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (we[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  initial for (int i = 0; i < (1<<ADDR_W); i++) mem[i] = init_word(i);

  always @(posedge clk) begin
    if (m_ce) begin
      if (m_we == 4'b0000) m_rdata <= mem[m_addr];
      else mem[m_addr] <= merge_bytes(mem[m_addr], m_wdata, m_we);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i_req = 1'b1; d_req = 1'b1;
    i_addr = 32'h0; d_addr = 32'h40; d_we = 4'b0000; d_wdata = '0;
    @(negedge clk);
    checks++;
    if ({i_gnt, d_gnt, m_ce} !== 3'b000) begin
      errors++; $display("FAIL reset_gnt: got i/d/ce=%b want 000", {i_gnt, d_gnt, m_ce});
    end
    checks++;
    if (m_we !== 4'b0000) begin
      errors++; $display("FAIL reset_we: got %b want 0000", m_we);
    end
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({i_rvalid, d_rvalid} !== 2'b00) begin
      errors++; $display("FAIL reset_rvalid: got i/d=%b want 00", {i_rvalid, d_rvalid});
    end
    checks++;
    if ({i_gnt, d_gnt} !== 2'b01 || m_addr !== 11'd16) begin
      errors++; $display("FAIL reset_first_gnt: got i/d=%b addr=%0d want 01 addr=16",
                         {i_gnt, d_gnt}, m_addr);
    end
    tick();
    i_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    checks++;
    if (d_rvalid !== 1'b1 || d_rdata !== init_word(16)) begin
      errors++; $display("FAIL reset_first_read: got v=%b data=%h want 1 %h",
                         d_rvalid, d_rdata, init_word(16));
    end
    exp_d_hold = init_word(16);
  endtask

  task automatic test_i_only();
    tick();
    i_req = 1'b1; i_addr = 32'h10;
    @(negedge clk);
    checks++;
    if ({i_gnt, d_gnt, m_ce} !== 3'b101 || m_addr !== 11'd4 || m_we !== 4'b0000) begin
      errors++; $display("FAIL i_only_gnt: got i/d/ce=%b addr=%0d we=%b want 101 4 0000",
                         {i_gnt, d_gnt, m_ce}, m_addr, m_we);
    end
    tick();
    i_req = 1'b0;
    @(negedge clk);
    checks++;
    if (i_rvalid !== 1'b1 || d_rvalid !== 1'b0 || i_rdata !== init_word(4)) begin
      errors++; $display("FAIL i_only_resp: got iv=%b dv=%b data=%h want 1 0 %h",
                         i_rvalid, d_rvalid, i_rdata, init_word(4));
    end
    checks++;
    if (d_rdata !== exp_d_hold) begin
      errors++; $display("FAIL i_only_d_hold: got %h want %h", d_rdata, exp_d_hold);
    end
    exp_i_hold = init_word(4);
  endtask

  task automatic test_store_load();
    tick();
    d_req = 1'b1; d_we = 4'b0011; d_addr = 32'h20; d_wdata = 32'hAABB_CCDD;
    @(negedge clk);
    checks++;
    if (d_gnt !== 1'b1 || m_we !== 4'b0011 || m_addr !== 11'd8 || m_wdata !== 32'hAABB_CCDD) begin
      errors++; $display("FAIL store_drive: got g=%b we=%b addr=%0d wd=%h want 1 0011 8 aabbccdd",
                         d_gnt, m_we, m_addr, m_wdata);
    end
    tick();
    d_we = 4'b0000;
    @(negedge clk);
    checks++;
    if (d_gnt !== 1'b1 || d_rvalid !== 1'b0 || m_we !== 4'b0000) begin
      errors++; $display("FAIL load_gnt: got g=%b v=%b we=%b want 1 0 0000", d_gnt, d_rvalid, m_we);
    end
    tick();
    d_req = 1'b0;
    @(negedge clk);
    checks++;
    if (d_rvalid !== 1'b1 || d_rdata !== 32'hC0DE_CCDD) begin
      errors++; $display("FAIL load_data: got v=%b data=%h want 1 c0deccdd", d_rvalid, d_rdata);
    end
    tick();
    @(negedge clk);
    checks++;
    if (d_rvalid !== 1'b0 || d_rdata !== 32'hC0DE_CCDD) begin
      errors++; $display("FAIL load_hold: got v=%b data=%h want 0 c0deccdd", d_rvalid, d_rdata);
    end
    exp_d_hold = 32'hC0DE_CCDD;
  endtask

  task automatic test_starvation();
    logic exp_i, prev_i;
    prev_i = 1'b0;
    tick();
    i_req = 1'b1; d_req = 1'b1; d_we = 4'b0000; i_addr = 32'h80; d_addr = 32'h40;
    for (int k = 0; k < 10; k++) begin
      exp_i = (k == 4 || k == 9);
      @(negedge clk);
      checks++;
      if (i_gnt !== exp_i || d_gnt !== !exp_i) begin
        errors++; $display("FAIL starve_gnt[%0d]: got i/d=%b%b want %b%b",
                           k, i_gnt, d_gnt, exp_i, !exp_i);
      end
      if (k > 0) begin
        checks++;
        if (i_rvalid !== prev_i || d_rvalid !== !prev_i) begin
          errors++; $display("FAIL starve_rvalid[%0d]: got i/d=%b%b want %b%b",
                             k, i_rvalid, d_rvalid, prev_i, !prev_i);
        end
      end
      prev_i = exp_i;
      tick();
    end
    i_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    checks++;
    if (i_rvalid !== 1'b1 || d_rvalid !== 1'b0 || i_rdata !== init_word(32)) begin
      errors++; $display("FAIL starve_last: got iv=%b dv=%b data=%h want 1 0 %h",
                         i_rvalid, d_rvalid, i_rdata, init_word(32));
    end
    exp_i_hold = init_word(32);
    exp_d_hold = init_word(16);
  endtask

  task automatic test_interleave();
    int w [4] = '{1, 2, 3, 5};
    logic is_i, prev_is_i;
    prev_is_i = 1'b0;
    tick();
    for (int k = 0; k < 5; k++) begin
      is_i = (k % 2 == 0);
      if (k < 4) begin
        i_req = is_i; d_req = !is_i; d_we = 4'b0000;
        i_addr = 32'(w[k]) << 2; d_addr = 32'(w[k]) << 2;
      end else begin
        i_req = 1'b0; d_req = 1'b0;
      end
      @(negedge clk);
      if (k < 4) begin
        checks++;
        if (i_gnt !== is_i || d_gnt !== !is_i || m_addr !== ADDR_W'(w[k])) begin
          errors++; $display("FAIL inter_gnt[%0d]: got i/d=%b%b addr=%0d want %b%b %0d",
                             k, i_gnt, d_gnt, m_addr, is_i, !is_i, w[k]);
        end
      end
      if (k > 0) begin
        if (prev_is_i) exp_i_hold = init_word(w[k-1]);
        else exp_d_hold = init_word(w[k-1]);
        checks++;
        if (i_rvalid !== prev_is_i || d_rvalid !== !prev_is_i ||
            i_rdata !== exp_i_hold || d_rdata !== exp_d_hold) begin
          errors++; $display("FAIL inter_resp[%0d]: got iv/dv=%b%b i=%h d=%h want %b%b i=%h d=%h",
                             k, i_rvalid, d_rvalid, i_rdata, d_rdata,
                             prev_is_i, !prev_is_i, exp_i_hold, exp_d_hold);
        end
      end
      prev_is_i = is_i;
      tick();
    end
    @(negedge clk);
    checks++;
    if (i_rvalid !== 1'b0 || d_rvalid !== 1'b0 || i_rdata !== exp_i_hold || d_rdata !== exp_d_hold) begin
      errors++; $display("FAIL inter_idle_hold: got iv/dv=%b%b i=%h d=%h want 00 i=%h d=%h",
                         i_rvalid, d_rvalid, i_rdata, d_rdata, exp_i_hold, exp_d_hold);
    end
  endtask

  task automatic test_mid_reset();
    logic exp_i;
    tick();
    i_req = 1'b1; d_req = 1'b1; d_we = 4'b0000; i_addr = 32'h80; d_addr = 32'h24;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (d_gnt !== 1'b1 || i_gnt !== 1'b0) begin
        errors++; $display("FAIL midrst_pre_gnt[%0d]: got i/d=%b%b want 01", k, i_gnt, d_gnt);
      end
      tick();
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (d_rvalid !== 1'b0 || i_rvalid !== 1'b0) begin
      errors++; $display("FAIL midrst_drop: got i/d rvalid=%b%b want 00", i_rvalid, d_rvalid);
    end
    @(negedge clk);
    checks++;
    if ({i_gnt, d_gnt, m_ce} !== 3'b000) begin
      errors++; $display("FAIL midrst_gnt: got i/d/ce=%b want 000", {i_gnt, d_gnt, m_ce});
    end
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      exp_i = (k == 4);
      @(negedge clk);
      checks++;
      if (i_gnt !== exp_i || d_gnt !== !exp_i) begin
        errors++; $display("FAIL midrst_streak[%0d]: got i/d=%b%b want %b%b",
                           k, i_gnt, d_gnt, exp_i, !exp_i);
      end
      if (k == 0) begin
        checks++;
        if (d_rvalid !== 1'b0 || i_rvalid !== 1'b0) begin
          errors++; $display("FAIL midrst_post_rvalid: got i/d=%b%b want 00", i_rvalid, d_rvalid);
        end
      end
      tick();
    end
    i_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    checks++;
    if (i_rvalid !== 1'b1 || i_rdata !== init_word(32)) begin
      errors++; $display("FAIL midrst_i_resp: got v=%b data=%h want 1 %h",
                         i_rvalid, i_rdata, init_word(32));
    end
  endtask

  initial begin
    test_reset();
    test_i_only();
    test_store_load();
    test_starvation();
    test_interleave();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish want finish before 100000 ns");
    $fatal(1, "timeout");
  end

endmodule
